cpu_bus_master: RTL

//  Synthesizable, parametrised master for the UART DUT's async-style CPU bus (chip-select/rd/we strobes).

---
 rtl/cpu_bus_pkg.sv | 22 ++
 rtl/cpu_bus_master_stamp_gen.sv | 64 ++++++
 rtl/cpu_bus_master.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus master and its time-stamp generator.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } bus_state_e;

  localparam int SUB_PER_MS = 10;
  localparam int MS_PER_S   = 1000;
  localparam int ACQ_W      = 4;
  localparam int MS_W       = 12;
  localparam int SEC_W      = 32;

  // Width able to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cpu_bus_master_stamp_gen.sv
// Time-stamp generator: clock prescaler feeding cascaded sub-ms / ms / second counters.
// Instantiated by cpu_bus_master only when STAMP_GEN_EN is defined.
module stamp_gen
  import cpu_bus_pkg::*;
#(
  parameter int CLK_PER_TICK = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ACQ_W-1:0] acq_o,
  output logic [MS_W-1:0]  ms_o,
  output logic [SEC_W-1:0] sec_o
);

  localparam int PRE_W = cnt_w(CLK_PER_TICK);

  logic [PRE_W-1:0] presc_q, presc_d;
  logic [ACQ_W-1:0] acq_q, acq_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             tick;

  assign tick = (presc_q == PRE_W'(CLK_PER_TICK - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    acq_d   = acq_q;
    ms_d    = ms_q;
    sec_d   = sec_q;
    // All carries resolve in the same cycle as the tick.
    if (tick) begin
      if (acq_q == ACQ_W'(SUB_PER_MS - 1)) begin
        acq_d = '0;
        if (ms_q == MS_W'(MS_PER_S - 1)) begin
          ms_d  = '0;
          sec_d = sec_q + 1'b1;
        end else begin
          ms_d = ms_q + 1'b1;
        end
      end else begin
        acq_d = acq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      acq_q   <= '0;
      ms_q    <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      acq_q   <= acq_d;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
    end
  end

  assign acq_o = acq_q;
  assign ms_o  = ms_q;
  assign sec_o = sec_q;

endmodule

// File: rtl/cpu_bus_master.sv
// Valid/ready to async-style CPU bus master with IRQ synchroniser and optional time stamps.
// Define STAMP_GEN_EN to build the time-stamp counters; otherwise the stamp ports read 0.
//
// state  | meaning
// IDLE   | CS high, req_ready=1, waiting for a request
// SETUP  | CS low, address (and write data) presented before the strobe
// STROBE | n_rd or n_we low; read data captured on the final strobe edge
// HOLD   | strobes released, CS/address/data held
module cpu_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int CLK_PER_TICK = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] AddrBus,
  output logic              n_ChipSelect,
  output logic              n_rd,
  output logic              n_we,
  output logic [DATA_W-1:0] DataBusI,
  input  logic [DATA_W-1:0] DataBusO,
  input  logic              p_IrqSig,
  output logic              irq_level,
  output logic              irq_rise,
  output logic [ACQ_W-1:0]  acqurate_stamp,
  output logic [MS_W-1:0]   millisecond_stamp,
  output logic [SEC_W-1:0]  second_stamp
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W   = cnt_w(MAX_CYC);

  bus_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q, ready_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] abus_q, abus_d;
  logic [DATA_W-1:0] dbus_q, dbus_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          rdata_d = write_q ? '0 : DataBusO;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus pins are decoded from the next state so every pin comes straight from a flop.
    ready_d = (state_d == IDLE);
    cs_d    = (state_d == IDLE);
    rd_d    = !((state_d == STROBE) && !write_d);
    we_d    = !((state_d == STROBE) && write_d);
    abus_d  = (state_d == IDLE) ? '0 : addr_d;
    dbus_d  = ((state_d != IDLE) && write_d) ? wdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      we_q        <= 1'b1;
      abus_q      <= '0;
      dbus_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      abus_q      <= abus_d;
      dbus_q      <= dbus_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign n_ChipSelect = cs_q;
  assign n_rd         = rd_q;
  assign n_we         = we_q;
  assign AddrBus      = abus_q;
  assign DataBusI     = dbus_q;

  // The rise pulse is registered alongside the second sync stage so both change together.
  logic sync1_q, level_q, rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= p_IrqSig;
      level_q <= sync1_q;
      rise_q  <= sync1_q && !level_q;
    end
  end

  assign irq_level = level_q;
  assign irq_rise  = rise_q;

`ifdef STAMP_GEN_EN
  stamp_gen #(
    .CLK_PER_TICK(CLK_PER_TICK)
  ) u_stamp (
    .clk  (clk),
    .rst  (rst),
    .acq_o(acqurate_stamp),
    .ms_o (millisecond_stamp),
    .sec_o(second_stamp)
  );
`else
  logic unused_tick_cfg;
  assign unused_tick_cfg   = (CLK_PER_TICK > 0);
  assign acqurate_stamp    = '0;
  assign millisecond_stamp = '0;
  assign second_stamp      = '0;
`endif

endmodule
